mult_ctrl_param: RTL and testbench

MULT_CTRL_PARAM -- requirements
Module: mult_ctrl_param

---
 rtl/mult_pkg.sv | 17 +
 rtl/step_counter.sv | 28 ++
 rtl/mult_ctrl_param.sv | 127 ++++++++++++
 tb/tb_mult_ctrl_param.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and helpers for the shift-add multiplier controller.
package mult_pkg;

   // Controller states: wait for start, add step, shift step, wait for Run to drop.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ADD   = 2'd1,
      SHIFT = 2'd2,
      HOLD  = 2'd3
   } state_t;

   // Width of a counter that must hold 0..width-1 (at least one bit).
   function automatic int step_width(input int width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/step_counter.sv
// Bit-step counter: cleared on request, incremented per step, never passes WIDTH-1.
module step_counter
   import mult_pkg::*;
#(
   parameter int WIDTH = 8,
   localparam int CW = step_width(WIDTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          inc,
   output logic [CW-1:0] count
);

   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   // Clear has priority; increment saturates at the last step index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != LAST)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/mult_ctrl_param.sv
// Control unit for a WIDTH-bit shift-add multiplier (unsigned or two's complement).
// Run is a level request: one Run level produces exactly one multiply, and the
// controller parks in HOLD until Run is released. In signed mode the final
// step subtracts the multiplicand instead of adding it (MSB carries weight -2^(W-1)).
module mult_ctrl_param
   import mult_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CW    = step_width(WIDTH)
) (
   input  logic          Clk,
   input  logic          Reset_n,
   input  logic          Run,
   input  logic          ClearA_LoadB,
   input  logic          M,
   input  logic          Signed,
   input  logic          Abort,
   output logic          Clr_Ld,
   output logic          Shift,
   output logic          Add,
   output logic          Sub,
   output logic          Busy,
   output logic          Done,
   output logic [CW-1:0] Step
);

   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t state;
   state_t next_state;
   logic   signed_flag;
   logic   last_step;
   logic   cnt_clr;
   logic   cnt_inc;

   assign last_step = (Step == LAST);

   // Counter is held at zero in IDLE and cleared on every return to IDLE,
   // so Step reads 0 whenever the controller is idle.
   assign cnt_clr = (state == IDLE) || (next_state == IDLE);
   assign cnt_inc = (state == SHIFT) && !Abort && !last_step;

   step_counter #(
      .WIDTH (WIDTH)
   ) u_step_counter (
      .clk   (Clk),
      .rst_n (Reset_n),
      .clr   (cnt_clr),
      .inc   (cnt_inc),
      .count (Step)
   );

   // State register.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Signed mode is captured once at the start edge and ignored afterwards.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         signed_flag <= 1'b0;
      end else if ((state == IDLE) && Run && !Abort) begin
         signed_flag <= Signed;
      end
   end

   // Next-state and output decode; Abort masks the step controls in its cycle.
   always_comb begin
      next_state = state;
      Clr_Ld     = 1'b0;
      Shift      = 1'b0;
      Add        = 1'b0;
      Sub        = 1'b0;
      Busy       = 1'b0;
      Done       = 1'b0;
      unique case (state)
         IDLE: begin
            Clr_Ld = ClearA_LoadB;
            if (Run && !Abort) begin
               next_state = ADD;
            end
         end
         ADD: begin
            Busy = 1'b1;
            if (Abort) begin
               next_state = IDLE;
            end else begin
               next_state = SHIFT;
               if (last_step) begin
                  Sub = M & signed_flag;
                  Add = M & ~signed_flag;
               end else begin
                  Add = M;
               end
            end
         end
         SHIFT: begin
            Busy = 1'b1;
            if (Abort) begin
               next_state = IDLE;
            end else begin
               Shift = 1'b1;
               if (last_step) begin
                  Done       = 1'b1;
                  next_state = HOLD;
               end else begin
                  next_state = ADD;
               end
            end
         end
         HOLD: begin
            Clr_Ld = ClearA_LoadB;
            if (!Run) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mult_ctrl_param.sv
// Self-checking bench for mult_ctrl_param at WIDTH = 8, 4 and 16.
module tb_mult_ctrl_param;

   logic Clk     = 1'b0;
   logic Reset_n = 1'b0;

   // Clock: 10 time-unit period.
   always #5 Clk = ~Clk;

   // Per-instance stimulus/response bits: index 0 -> WIDTH 8, 1 -> WIDTH 4, 2 -> WIDTH 16.
   logic [2:0] run   = '0;
   logic [2:0] clra  = '0;
   logic [2:0] m     = '0;
   logic [2:0] sgn   = '0;
   logic [2:0] abort = '0;
   logic [2:0] clr_ld, shift, add, sub, busy, done;
   logic [2:0] step_a;
   logic [1:0] step_b;
   logic [3:0] step_c;

   int widths[3] = '{8, 4, 16};
   int n_checks  = 0;
   int n_fail    = 0;

   mult_ctrl_param #(.WIDTH(8)) u_w8 (
      .Clk(Clk), .Reset_n(Reset_n), .Run(run[0]), .ClearA_LoadB(clra[0]), .M(m[0]),
      .Signed(sgn[0]), .Abort(abort[0]), .Clr_Ld(clr_ld[0]), .Shift(shift[0]),
      .Add(add[0]), .Sub(sub[0]), .Busy(busy[0]), .Done(done[0]), .Step(step_a)
   );

   mult_ctrl_param #(.WIDTH(4)) u_w4 (
      .Clk(Clk), .Reset_n(Reset_n), .Run(run[1]), .ClearA_LoadB(clra[1]), .M(m[1]),
      .Signed(sgn[1]), .Abort(abort[1]), .Clr_Ld(clr_ld[1]), .Shift(shift[1]),
      .Add(add[1]), .Sub(sub[1]), .Busy(busy[1]), .Done(done[1]), .Step(step_b)
   );

   mult_ctrl_param #(.WIDTH(16)) u_w16 (
      .Clk(Clk), .Reset_n(Reset_n), .Run(run[2]), .ClearA_LoadB(clra[2]), .M(m[2]),
      .Signed(sgn[2]), .Abort(abort[2]), .Clr_Ld(clr_ld[2]), .Shift(shift[2]),
      .Add(add[2]), .Sub(sub[2]), .Busy(busy[2]), .Done(done[2]), .Step(step_c)
   );

   function automatic int get_step(input int i);
      case (i)
         0:       return int'(step_a);
         1:       return int'(step_b);
         default: return int'(step_c);
      endcase
   endfunction

   // Single comparison point: counts and reports.
   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Outputs expected whenever the controller is not stepping (IDLE, HOLD, reset).
   task automatic check_quiet(input int i, input string tag);
      check({tag, " busy"},   int'(busy[i]),   0);
      check({tag, " done"},   int'(done[i]),   0);
      check({tag, " shift"},  int'(shift[i]),  0);
      check({tag, " add"},    int'(add[i]),    0);
      check({tag, " sub"},    int'(sub[i]),    0);
      check({tag, " clr_ld"}, int'(clr_ld[i]), int'(clra[i]));
   endtask

   // One multiply on instance i. The reference: cycle k of the operation is the
   // add phase (k even) or shift phase (k odd) of bit k/2; bit W-1 subtracts in
   // signed mode. Run stays high for run_cycles cycles counted from the start cycle.
   task automatic do_mult(input int i, input bit sg, input logic [31:0] mp,
                          input int abort_k, input int run_cycles, input string tag);
      int w;
      int n_add, n_sub, n_shift, n_done;
      int st;
      bit is_add, mb, aborted, last;
      w = widths[i];
      n_add = 0; n_sub = 0; n_shift = 0; n_done = 0;
      aborted = 1'b0;
      @(negedge Clk);
      abort[i] = 1'b0;
      run[i]   = 1'b1;
      sgn[i]   = sg;
      check({tag, " start step"}, get_step(i), 0);
      check({tag, " start busy"}, int'(busy[i]), 0);
      @(posedge Clk); #1;
      for (int k = 0; k < 2 * w; k++) begin
         st     = k / 2;
         is_add = (k % 2) == 0;
         mb     = mp[st];
         last   = (st == w - 1);
         m[i]     = mb;
         sgn[i]   = 1'($urandom_range(0, 1));
         clra[i]  = 1'($urandom_range(0, 1));
         run[i]   = (k + 1 < run_cycles);
         abort[i] = (k == abort_k);
         @(negedge Clk);
         check($sformatf("%s k%0d busy", tag, k), int'(busy[i]), 1);
         check($sformatf("%s k%0d step", tag, k), get_step(i), st);
         check($sformatf("%s k%0d clr_ld", tag, k), int'(clr_ld[i]), 0);
         if (k == abort_k) begin
            check($sformatf("%s k%0d abort add", tag, k), int'(add[i]), 0);
            check($sformatf("%s k%0d abort sub", tag, k), int'(sub[i]), 0);
            check($sformatf("%s k%0d abort shift", tag, k), int'(shift[i]), 0);
            check($sformatf("%s k%0d abort done", tag, k), int'(done[i]), 0);
            @(posedge Clk); #1;
            abort[i] = 1'b0;
            run[i]   = 1'b0;
            @(negedge Clk);
            check({tag, " after abort busy"}, int'(busy[i]), 0);
            check({tag, " after abort step"}, get_step(i), 0);
            check({tag, " after abort done"}, int'(done[i]), 0);
            aborted = 1'b1;
            break;
         end
         check($sformatf("%s k%0d add", tag, k), int'(add[i]),
               int'(is_add && mb && !(sg && last)));
         check($sformatf("%s k%0d sub", tag, k), int'(sub[i]),
               int'(is_add && mb && sg && last));
         check($sformatf("%s k%0d shift", tag, k), int'(shift[i]), int'(!is_add));
         check($sformatf("%s k%0d done", tag, k), int'(done[i]), int'(!is_add && last));
         check($sformatf("%s k%0d add&sub", tag, k), int'(add[i] & sub[i]), 0);
         n_add   += int'(add[i]);
         n_sub   += int'(sub[i]);
         n_shift += int'(shift[i]);
         n_done  += int'(done[i]);
         @(posedge Clk); #1;
      end
      if (!aborted) begin
         check({tag, " shift total"}, n_shift, w);
         check({tag, " done total"}, n_done, 1);
         check({tag, " sub total"}, n_sub, int'(sg && mp[w-1]));
         // HOLD: no second multiply while Run stays high.
         if (run_cycles > 2 * w) begin
            for (int h = 0; h < 4; h++) begin
               clra[i] = 1'($urandom_range(0, 1));
               @(negedge Clk);
               check($sformatf("%s hold%0d", tag, h), int'(busy[i]), 0);
               check_quiet(i, $sformatf("%s hold%0d", tag, h));
               @(posedge Clk); #1;
            end
         end
         run[i] = 1'b0;
         @(negedge Clk);
         check_quiet(i, {tag, " hold exit"});
         @(posedge Clk); #1;
         @(negedge Clk);
         check_quiet(i, {tag, " idle"});
         check({tag, " idle step"}, get_step(i), 0);
      end
      m[i]   = 1'b0;
      sgn[i] = 1'b0;
   endtask

   initial begin
      int i;
      bit sg;
      logic [31:0] mp;
      int ak;
      // Reset state, including asynchronous Clr_Ld pass-through.
      #2;
      for (int j = 0; j < 3; j++) check_quiet(j, $sformatf("reset%0d", j));
      clra = 3'b101;
      #1;
      for (int j = 0; j < 3; j++) begin
         check_quiet(j, $sformatf("reset clr%0d", j));
         check($sformatf("reset step%0d", j), get_step(j), 0);
      end
      clra = '0;
      @(negedge Clk);
      Reset_n = 1'b1;

      // Signed, M=1, Run pulse of 3 cycles.
      do_mult(0, 1'b1, 32'hFFFF_FFFF, -1, 3, "w8s");
      // Unsigned, M=1: all adds, no sub.
      do_mult(0, 1'b0, 32'hFFFF_FFFF, -1, 3, "w8u");
      // WIDTH 4, M = 1,0,1,1 per step, signed.
      do_mult(1, 1'b1, 32'h0000_000D, -1, 2, "w4s");
      // Abort in SHIFT at step 3.
      do_mult(0, 1'b1, 32'h0000_00A5, 7, 20, "w8abort");

      // Abort in IDLE blocks a start.
      @(negedge Clk);
      run[0] = 1'b1; abort[0] = 1'b1;
      @(posedge Clk); #1;
      @(negedge Clk);
      check("idle abort busy", int'(busy[0]), 0);
      run[0] = 1'b0; abort[0] = 1'b0;

      // Asynchronous reset mid-ADD, then restart with Run held.
      @(negedge Clk);
      run[0] = 1'b1; m[0] = 1'b1; sgn[0] = 1'b1;
      @(posedge Clk); #1;
      @(posedge Clk); #1;
      @(posedge Clk); #1;
      check("pre-reset busy", int'(busy[0]), 1);
      check("pre-reset add", int'(add[0]), 1);
      #2;
      Reset_n = 1'b0;
      #1;
      check_quiet(0, "mid reset");
      check("mid reset step", get_step(0), 0);
      Reset_n = 1'b1;
      do_mult(0, 1'b1, 32'h0000_0033, -1, 3, "w8post");

      // WIDTH 16 with Run held throughout.
      do_mult(2, 1'b0, 32'h0000_5A3C, -1, 1000, "w16");

      // Random operations on random instances.
      for (int r = 0; r < 8; r++) begin
         i  = $urandom_range(0, 2);
         sg = 1'($urandom_range(0, 1));
         mp = $urandom;
         ak = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2 * widths[i] - 1) : -1;
         do_mult(i, sg, mp, ak, $urandom_range(1, 2 * widths[i] + 6), $sformatf("rnd%0d", r));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
